// File: rtl/store_buffer_4to2_pkg.sv
// rtl/store_buffer_4to2_pkg.sv - shared widths, entry type and address compare for the store buffer
package sb_pkg;

   localparam int ISSUE_W = 4;
   localparam int DRAIN_W = 2;
   localparam int OFF_W   = $clog2(ISSUE_W);
   localparam int CNT_W   = $clog2(ISSUE_W + 1);
   localparam int SB_AW   = 32;
   localparam int SB_DW   = 32;

   typedef struct packed {
      logic [SB_AW-1:0] addr;
      logic [SB_DW-1:0] data;
   } sb_entry_t;

   // Byte offset within the word is ignored: all stores are whole words.
   function automatic logic word_match(input logic [SB_AW-1:0] a, input logic [SB_AW-1:0] b);
      return a[SB_AW-1:2] == b[SB_AW-1:2];
   endfunction

endpackage

// File: rtl/store_buffer_4to2_if.sv
// rtl/store_buffer_4to2_if.sv - store, drain and forwarding signals between pipeline and store buffer
interface store_buffer_4to2_if
   import sb_pkg::*;
#(
   parameter int AW = SB_AW,
   parameter int DW = SB_DW
);

   logic [ISSUE_W-1:0]          st_we;
   logic [ISSUE_W-1:0][AW-1:0]  st_addr;
   logic [ISSUE_W-1:0][DW-1:0]  st_data;
   logic                        st_ready;

   logic                        we_1;
   logic                        we_2;
   logic [AW-1:0]               dataadr_1;
   logic [AW-1:0]               dataadr_2;
   logic [DW-1:0]               writedata_1;
   logic [DW-1:0]               writedata_2;

   logic [ISSUE_W-1:0][AW-1:0]  ld_addr;
   logic [ISSUE_W-1:0]          fwd_hit;
   logic [ISSUE_W-1:0][DW-1:0]  fwd_data;

   logic                        empty;

   modport master (
      output st_we, st_addr, st_data, ld_addr,
      input  st_ready, we_1, we_2, dataadr_1, dataadr_2, writedata_1, writedata_2,
      input  fwd_hit, fwd_data, empty
   );

   modport slave (
      input  st_we, st_addr, st_data, ld_addr,
      output st_ready, we_1, we_2, dataadr_1, dataadr_2, writedata_1, writedata_2,
      output fwd_hit, fwd_data, empty
   );

endinterface

// File: rtl/store_buffer_4to2_compact.sv
// rtl/store_buffer_4to2_compact.sv - prefix popcount of lane store enables into slot offsets
module sb_compact
   import sb_pkg::*;
(
   input  logic [ISSUE_W-1:0]            we_i,
   output logic [ISSUE_W-1:0][OFF_W-1:0] offset_o,
   output logic [CNT_W-1:0]              n_in_o
);

   // Each enabled lane lands at wr_ptr plus the number of older enabled lanes.
   always_comb begin
      logic [CNT_W-1:0] run;
      run      = '0;
      offset_o = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
         offset_o[i] = run[OFF_W-1:0];
         run         = run + CNT_W'(we_i[i]);
      end
      n_in_o = run;
   end

endmodule

// File: rtl/store_buffer_4to2.sv
// rtl/store_buffer_4to2.sv - 4-wide enqueue, 2-wide drain store buffer with load forwarding
module store_buffer_4to2
   import sb_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
) (
   input  logic                 clk,
   input  logic                 reset,
   store_buffer_4to2_if.slave   bus
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;
   localparam logic [PW-1:0] DEPTH_C     = PW'(DEPTH);
   localparam logic [PW-1:0] READY_MAX_C = PW'(DEPTH - ISSUE_W);

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] count_q, count_d;
   sb_entry_t     entries_q [DEPTH];

   logic                            st_ready;
   logic [ISSUE_W-1:0][OFF_W-1:0]   lane_off;
   logic [CNT_W-1:0]                n_in_raw;
   logic [PW-1:0]                   n_in;
   logic [ISSUE_W-1:0][IW-1:0]      slot_idx;

   logic [IW-1:0]                   head_idx, next_idx;
   sb_entry_t                       head_e, next_e;
   logic [DRAIN_W-1:0]              drain_we;
   logic [PW-1:0]                   n_out;

   logic [DEPTH-1:0][IW-1:0]        age_idx;
   logic [DEPTH-1:0]                age_valid;
   logic [ISSUE_W-1:0]              fwd_hit;
   logic [ISSUE_W-1:0][DW-1:0]      fwd_data;

   sb_compact u_compact (
      .we_i     (bus.st_we),
      .offset_o (lane_off),
      .n_in_o   (n_in_raw)
   );

   // Only the registered count gates acceptance; same-cycle drains never free room early.
   assign st_ready = (count_q <= READY_MAX_C);
   assign n_in     = st_ready ? PW'(n_in_raw) : '0;

   always_comb begin
      slot_idx = '0;
      for (int l = 0; l < ISSUE_W; l++) begin
         slot_idx[l] = wr_ptr_q[IW-1:0] + IW'(lane_off[l]);
      end
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < ISSUE_W; l++) begin
         if (st_ready && bus.st_we[l]) begin
            entries_q[slot_idx[l]] <= '{addr: bus.st_addr[l], data: bus.st_data[l]};
         end
      end
   end

   assign head_idx = rd_ptr_q[IW-1:0];
   assign next_idx = head_idx + 1'b1;
   assign head_e   = entries_q[head_idx];
   assign next_e   = entries_q[next_idx];

   // A second port write to the same word would race in dmem, so it waits a cycle.
   always_comb begin
      drain_we    = '0;
      drain_we[0] = (count_q != '0);
      drain_we[1] = (count_q >= PW'(2)) && !word_match(head_e.addr, next_e.addr);
      n_out       = PW'(drain_we[0]) + PW'(drain_we[1]);
   end

   always_comb begin
      count_d  = count_q + n_in - n_out;
      rd_ptr_d = rd_ptr_q + n_out;
      wr_ptr_d = wr_ptr_q + n_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      age_idx   = '0;
      age_valid = '0;
      for (int k = 0; k < DEPTH; k++) begin
         age_idx[k]   = rd_ptr_q[IW-1:0] + IW'(k);
         age_valid[k] = (PW'(k) < count_q);
      end
   end

   // Scan oldest to youngest so the last match left standing is the youngest store.
   always_comb begin
      fwd_hit  = '0;
      fwd_data = '0;
      for (int l = 0; l < ISSUE_W; l++) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (age_valid[k] && word_match(entries_q[age_idx[k]].addr, bus.ld_addr[l])) begin
               fwd_hit[l]  = 1'b1;
               fwd_data[l] = entries_q[age_idx[k]].data;
            end
         end
      end
   end

   assign bus.st_ready    = st_ready;
   assign bus.we_1        = drain_we[0];
   assign bus.we_2        = drain_we[1];
   assign bus.dataadr_1   = head_e.addr;
   assign bus.dataadr_2   = next_e.addr;
   assign bus.writedata_1 = head_e.data;
   assign bus.writedata_2 = next_e.data;
   assign bus.fwd_hit     = fwd_hit;
   assign bus.fwd_data    = fwd_data;
   assign bus.empty       = (count_q == '0);

   sb_no_overflow: assert property (@(posedge clk) disable iff (!reset) count_d <= DEPTH_C);

endmodule

// File: tb/tb_store_buffer_4to2.sv
// tb/tb_store_buffer_4to2.sv - scoreboard bench for store_buffer_4to2
module tb_store_buffer_4to2;

   localparam int DEPTH = 8;
   localparam int AW    = 32;
   localparam int DW    = 32;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   store_buffer_4to2_if #(.AW(AW), .DW(DW)) sb_if ();

   store_buffer_4to2 #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sb_if)
   );

   int checks = 0;
   int errors = 0;
   logic [AW+DW-1:0] exp_q [$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h required %h", nm, act, req);
      end
   endtask

   task automatic pop_check(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic [AW+DW-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s unexpected write %h/%h required none", nm, a, d);
      end else begin
         e = exp_q.pop_front();
         if ({a, d} !== e) begin
            errors++;
            $display("FAIL %s got %h/%h required %h/%h", nm, a, d, e[AW+DW-1:DW], e[DW-1:0]);
         end
      end
   endtask

   // Drain monitor: every dmem write must be the next store in program order.
   always @(negedge clk) begin
      if (reset) begin
         if (sb_if.we_1) pop_check("drain_port1", sb_if.dataadr_1, sb_if.writedata_1);
         if (sb_if.we_2) begin
            pop_check("drain_port2", sb_if.dataadr_2, sb_if.writedata_2);
            checks++;
            if (!sb_if.we_1 || sb_if.dataadr_1[AW-1:2] == sb_if.dataadr_2[AW-1:2]) begin
               errors++;
               $display("FAIL dual_write we_1=%b a1=%h a2=%h required we_1=1 and distinct words",
                        sb_if.we_1, sb_if.dataadr_1, sb_if.dataadr_2);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at edge+1; returns at edge+1 of the cycle after the bundle is accepted.
   task automatic issue(input logic [3:0] we,
                        input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                        input logic [AW-1:0] a3, input logic [DW-1:0] d3);
      int n;
      sb_if.st_we   = we;
      sb_if.st_addr = {a3, a2, a1, a0};
      sb_if.st_data = {d3, d2, d1, d0};
      #1;
      n = 0;
      while (!sb_if.st_ready && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (!sb_if.st_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout st_ready=0 required 1");
      end else begin
         for (int l = 0; l < 4; l++) begin
            if (we[l]) exp_q.push_back({sb_if.st_addr[l], sb_if.st_data[l]});
         end
      end
      @(posedge clk);
      #1;
      sb_if.st_we = '0;
   endtask

   task automatic drain_wait(input string nm);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
      chk({nm, "_empty"}, 64'(sb_if.empty), 64'd1);
   endtask

   initial begin
      int b;
      int n;
      bit saw_stall;

      sb_if.st_we   = '0;
      sb_if.st_addr = '0;
      sb_if.st_data = '0;
      sb_if.ld_addr = {32'h9000, 32'h9000, 32'h9000, 32'h9000};
      #12;
      chk("rst_we_1", 64'(sb_if.we_1), 64'd0);
      chk("rst_we_2", 64'(sb_if.we_2), 64'd0);
      chk("rst_fwd_hit", 64'(sb_if.fwd_hit), 64'd0);
      chk("rst_empty", 64'(sb_if.empty), 64'd1);
      chk("rst_st_ready", 64'(sb_if.st_ready), 64'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick();

      // single store on lane 2
      issue(4'b0100, 0, 0, 0, 0, 32'h10, 32'hAA, 0, 0);
      chk("t1_we_1", 64'(sb_if.we_1), 64'd1);
      chk("t1_addr_1", 64'(sb_if.dataadr_1), 64'h10);
      chk("t1_data_1", 64'(sb_if.writedata_1), 64'hAA);
      chk("t1_we_2", 64'(sb_if.we_2), 64'd0);
      tick();
      chk("t1_empty", 64'(sb_if.empty), 64'd1);

      // full bundle, distinct words: two drains per cycle
      issue(4'b1111, 32'h0, 32'd1, 32'h4, 32'd2, 32'h8, 32'd3, 32'hC, 32'd4);
      chk("t2_c1_addr_1", 64'(sb_if.dataadr_1), 64'h0);
      chk("t2_c1_data_2", {sb_if.dataadr_2, sb_if.writedata_2}, {32'h4, 32'd2});
      chk("t2_c1_we", {62'd0, sb_if.we_2, sb_if.we_1}, 64'd3);
      tick();
      chk("t2_c2_port1", {sb_if.dataadr_1, sb_if.writedata_1}, {32'h8, 32'd3});
      chk("t2_c2_port2", {sb_if.dataadr_2, sb_if.writedata_2}, {32'hC, 32'd4});
      tick();
      chk("t2_empty", 64'(sb_if.empty), 64'd1);

      // back-to-back full bundles: stall when fewer than four slots free
      b = 0;
      n = 0;
      saw_stall = 0;
      while (b < 12 && n < 200) begin
         sb_if.st_we = 4'hF;
         for (int l = 0; l < 4; l++) begin
            sb_if.st_addr[l] = 32'h1000 + 32'((b * 4 + l) * 4);
            sb_if.st_data[l] = 32'h100 + 32'(b * 4 + l);
         end
         #1;
         chk("t3_st_ready", 64'(sb_if.st_ready), 64'((DEPTH - exp_q.size()) >= 4));
         if (sb_if.st_ready) begin
            for (int l = 0; l < 4; l++) exp_q.push_back({sb_if.st_addr[l], sb_if.st_data[l]});
            b++;
         end else begin
            saw_stall = 1;
         end
         @(posedge clk);
         #1;
         n++;
      end
      sb_if.st_we = '0;
      chk("t3_stall_seen", 64'(saw_stall), 64'd1);
      drain_wait("t3");

      // two stores to the same word drain one per cycle
      issue(4'b0011, 32'h20, 32'd1, 32'h20, 32'd2, 0, 0, 0, 0);
      chk("t4_c1", {sb_if.we_1, sb_if.we_2, sb_if.writedata_1}, {1'b1, 1'b0, 32'd1});
      tick();
      chk("t4_c2", {sb_if.we_1, sb_if.we_2, sb_if.writedata_1}, {1'b1, 1'b0, 32'd2});
      tick();
      chk("t4_empty", 64'(sb_if.empty), 64'd1);

      // forwarding picks the youngest matching store
      sb_if.ld_addr = {32'h40, 32'h1000, 32'h1000, 32'h44};
      issue(4'b0011, 32'h40, 32'd5, 32'h40, 32'd9, 0, 0, 0, 0);
      chk("t5_fwd_hit", 64'(sb_if.fwd_hit), 64'b1000);
      chk("t5_fwd_data3", 64'(sb_if.fwd_data[3]), 64'd9);
      chk("t5_fwd_data0", 64'(sb_if.fwd_data[0]), 64'd0);
      tick();
      chk("t5_fwd_data3_late", {sb_if.fwd_hit, sb_if.fwd_data[3]}, {4'b1000, 32'd9});
      drain_wait("t5");
      chk("t5_fwd_hit_gone", 64'(sb_if.fwd_hit), 64'd0);

      // reset mid-operation with six pending entries
      sb_if.ld_addr = {32'h100, 32'h100, 32'h100, 32'h100};
      issue(4'b1111, 32'h100, 32'h61, 32'h100, 32'h62, 32'h100, 32'h63, 32'h100, 32'h64);
      issue(4'b0111, 32'h100, 32'h65, 32'h100, 32'h66, 32'h100, 32'h67, 0, 0);
      chk("t6_pre_fwd", {sb_if.fwd_hit, sb_if.fwd_data[0]}, {4'hF, 32'h67});
      chk("t6_pre_st_ready", 64'(sb_if.st_ready), 64'd0);
      #2;
      reset = 1'b0;
      exp_q.delete();
      #1;
      chk("t6_rst_we", {62'd0, sb_if.we_1, sb_if.we_2}, 64'd0);
      chk("t6_rst_empty", 64'(sb_if.empty), 64'd1);
      chk("t6_rst_fwd_hit", 64'(sb_if.fwd_hit), 64'd0);
      chk("t6_rst_st_ready", 64'(sb_if.st_ready), 64'd1);
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("t6_post_empty", 64'(sb_if.empty), 64'd1);
      chk("t6_post_we_1", 64'(sb_if.we_1), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
